// File: rtl/floo_axis_bridge_pkg.sv
// Shared types for the NoC-over-AXIS bridge: flit header enum, default flit/AXIS
// structs and the saturating-counter helper.
package floo_axis_bridge_pkg;

  typedef enum logic {
    RequestFlit  = 1'b0,
    ResponseFlit = 1'b1
  } flit_type_header_t;

  localparam int FlitDataWidth = 32;
  localparam int AxisDataWidth = FlitDataWidth + 1;
  localparam int AxisStrbWidth = (AxisDataWidth + 7) / 8;

  typedef struct packed {
    flit_type_header_t        hdr;
    logic [FlitDataWidth-1:0] flit_data;
  } floo_axis_data_t;

  typedef struct packed {
    logic                     valid;
    logic                     ready;
    logic [FlitDataWidth-1:0] data;
  } floo_req_flit_t;

  typedef struct packed {
    logic                     valid;
    logic                     ready;
    logic [FlitDataWidth-1:0] data;
  } floo_rsp_flit_t;

  typedef struct packed {
    logic [AxisDataWidth-1:0] data;
    logic [AxisStrbWidth-1:0] strb;
    logic [AxisStrbWidth-1:0] keep;
    logic                     last;
    logic [3:0]               id;
    logic [3:0]               dest;
    logic [7:0]               user;
  } floo_axis_t_chan_t;

  typedef struct packed {
    logic              tvalid;
    floo_axis_t_chan_t t;
  } floo_axis_req_t;

  typedef struct packed {
    logic tready;
  } floo_axis_rsp_t;

  // Holds at max_value instead of wrapping.
  function automatic logic [31:0] sat_incr(input logic [31:0] value, input logic [31:0] max_value);
    return (value >= max_value) ? max_value : value + 32'd1;
  endfunction

endpackage

// File: rtl/floo_axis_rx_fifo.sv
// Per-channel flit FIFO: registered storage, head presented combinationally, no
// fall-through, so a pushed entry is visible the cycle after it is written.
module floo_axis_rx_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  localparam int UsageWidth = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic [UsageWidth-1:0] usage_o
);

  localparam int PtrWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PtrWidth-1:0]   wr_ptr_reg;
  logic [PtrWidth-1:0]   rd_ptr_reg;
  logic [UsageWidth-1:0] usage_reg;
  logic                  push;
  logic                  pop;

  assign full_o  = (usage_reg == UsageWidth'(DEPTH));
  assign ready_o = !full_o;
  assign valid_o = (usage_reg != '0);
  assign data_o  = mem[rd_ptr_reg];
  assign usage_o = usage_reg;
  assign push    = valid_i && !full_o;
  assign pop     = valid_o && ready_i;

  function automatic logic [PtrWidth-1:0] ptr_incr(input logic [PtrWidth-1:0] ptr);
    return (ptr == PtrWidth'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_reg] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      usage_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_incr(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_incr(rd_ptr_reg);
      if (push && !pop) begin
        usage_reg <= usage_reg + 1'b1;
      end else if (pop && !push) begin
        usage_reg <= usage_reg - 1'b1;
      end
    end
  end

endmodule

// File: rtl/floo_axis_flit_receiver.sv
// Receive side of the NoC-over-AXIS link: steers each AXIS beat by its header bit
// into an independent request or response FIFO and counts accepted beats.
module floo_axis_flit_receiver
  import floo_axis_bridge_pkg::*;
#(
  parameter type rsp_flit_t  = floo_rsp_flit_t,
  parameter type req_flit_t  = floo_req_flit_t,
  parameter type axis_req_t  = floo_axis_req_t,
  parameter type axis_rsp_t  = floo_axis_rsp_t,
  parameter type axis_data_t = floo_axis_data_t,
  parameter int  FifoDepth   = 4,
  parameter int  CntWidth    = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  axis_req_t           axis_in_req_i,
  output axis_rsp_t           axis_in_rsp_o,
  output req_flit_t           req_o,
  input  req_flit_t           req_i,
  output rsp_flit_t           rsp_o,
  input  rsp_flit_t           rsp_i,
  output logic [CntWidth-1:0] req_cnt_o,
  output logic [CntWidth-1:0] rsp_cnt_o
);

  localparam int FlitBitSize = $bits(axis_data_t) - 1;
  localparam int UsageWidth  = $clog2(FifoDepth + 1);
  localparam logic [CntWidth-1:0] CntMax = '1;

  axis_data_t             t_data;
  logic                   hdr;
  logic                   tready;
  logic                   accept;
  logic [1:0]             chan_full;
  logic [1:0]             chan_push;
  logic [1:0]             chan_pop_ready;
  logic [1:0]             chan_in_ready;
  logic [1:0]             chan_valid;
  logic [FlitBitSize-1:0] chan_data  [2];
  logic [UsageWidth-1:0]  chan_usage [2];
  logic [CntWidth-1:0]    cnt_reg    [2];

  assign t_data = axis_data_t'(axis_in_req_i.t.data);
  assign hdr    = t_data.hdr;

  // Ready looks only at the targeted FIFO's fill level, never at the NoC side.
  assign tready = rst_ni && !chan_full[hdr];
  assign accept = axis_in_req_i.tvalid && tready;

  assign chan_pop_ready[0] = req_i.ready;
  assign chan_pop_ready[1] = rsp_i.ready;

  for (genvar gi = 0; gi < 2; gi++) begin : gen_chan
    assign chan_push[gi] = accept && (hdr == 1'(gi));

    floo_axis_rx_fifo #(
      .DATA_WIDTH(FlitBitSize),
      .DEPTH     (FifoDepth)
    ) i_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .valid_i(chan_push[gi]),
      .ready_o(chan_in_ready[gi]),
      .data_i (t_data.flit_data),
      .valid_o(chan_valid[gi]),
      .ready_i(chan_pop_ready[gi]),
      .data_o (chan_data[gi]),
      .full_o (chan_full[gi]),
      .usage_o(chan_usage[gi])
    );

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        cnt_reg[gi] <= '0;
      end else if (chan_push[gi]) begin
        cnt_reg[gi] <= CntWidth'(sat_incr(32'(cnt_reg[gi]), 32'(CntMax)));
      end
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni) !(chan_push[gi] && chan_full[gi]))
      else $error("push into full channel FIFO %0d", gi);
    assert property (@(posedge clk_i) disable iff (!rst_ni) chan_usage[gi] <= UsageWidth'(FifoDepth))
      else $error("channel FIFO %0d usage out of range", gi);
  end

  always_comb begin
    req_o       = '0;
    req_o.valid = chan_valid[0];
    req_o.data  = chan_data[0];
    rsp_o       = '0;
    rsp_o.valid = chan_valid[1];
    rsp_o.data  = chan_data[1];
    axis_in_rsp_o        = '0;
    axis_in_rsp_o.tready = tready;
  end

  assign req_cnt_o = cnt_reg[0];
  assign rsp_cnt_o = cnt_reg[1];

  // A stalled beat that is still offered must keep its tdata (and so its header).
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    (axis_in_req_i.tvalid && !tready) ##1 axis_in_req_i.tvalid |-> $stable(axis_in_req_i.t.data))
    else $error("AXIS tdata changed while stalled");

  logic unused_sigs;
  assign unused_sigs = ^{axis_in_req_i, req_i, rsp_i, chan_in_ready};

endmodule

// File: tb/tb_floo_axis_flit_receiver.sv
// Directed bench for floo_axis_flit_receiver: channel steering, latency, no-HOL,
// full-FIFO backpressure, counter saturation and mid-traffic reset.
module tb_floo_axis_flit_receiver;
  import floo_axis_bridge_pkg::*;

  logic           clk = 1'b0;
  logic           rst_n;
  floo_axis_req_t axis_req;
  floo_axis_rsp_t axis_rsp, axis_rsp_sat;
  floo_req_flit_t req_out, req_in, req_out_sat;
  floo_rsp_flit_t rsp_out, rsp_in, rsp_out_sat;
  logic [15:0]    req_cnt, rsp_cnt;
  logic [3:0]     req_cnt_sat, rsp_cnt_sat;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] req_seen[$];
  logic [31:0] rsp_seen[$];

  always #5 clk = ~clk;

  floo_axis_flit_receiver #(.FifoDepth(4), .CntWidth(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .axis_in_req_i(axis_req), .axis_in_rsp_o(axis_rsp),
    .req_o(req_out), .req_i(req_in), .rsp_o(rsp_out), .rsp_i(rsp_in),
    .req_cnt_o(req_cnt), .rsp_cnt_o(rsp_cnt)
  );

  floo_axis_flit_receiver #(.FifoDepth(4), .CntWidth(4)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n), .axis_in_req_i(axis_req), .axis_in_rsp_o(axis_rsp_sat),
    .req_o(req_out_sat), .req_i(req_in), .rsp_o(rsp_out_sat), .rsp_i(rsp_in),
    .req_cnt_o(req_cnt_sat), .rsp_cnt_o(rsp_cnt_sat)
  );

  always @(negedge clk) begin
    if (rst_n) begin
      if (req_out.valid && req_in.ready) req_seen.push_back(req_out.data);
      if (rsp_out.valid && rsp_in.ready) rsp_seen.push_back(rsp_out.data);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    axis_req.tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_seen.delete();
    rsp_seen.delete();
  endtask

  // Offers one beat and returns 1ns after the edge that accepted it.
  task automatic send_beat(input logic hdr, input logic [31:0] data);
    bit done = 0;
    axis_req.tvalid = 1'b1;
    axis_req.t.data = {hdr, data};
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (axis_rsp.tready) begin
        done = 1;
        break;
      end
    end
    if (!done) check("send_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    axis_req.tvalid = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [31:0] a_vec [3];
    logic [31:0] d_vec [4];
    logic [31:0] r_vec [5];
    a_vec = '{32'hA000_000A, 32'hB000_000B, 32'hC000_000C};
    d_vec = '{32'hD000_0000, 32'hD000_0001, 32'hD000_0002, 32'hD000_0003};
    r_vec = '{32'h5000_0000, 32'h5000_0001, 32'h5000_0002, 32'h5000_0003, 32'h5000_0004};

    axis_req = '0;
    req_in = '0;
    rsp_in = '0;
    rst_n = 1'b0;
    axis_req.tvalid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tready", 64'(axis_rsp.tready), 64'd0);
    check("rst_req_valid", 64'(req_out.valid), 64'd0);
    check("rst_rsp_valid", 64'(rsp_out.valid), 64'd0);
    check("rst_req_cnt", 64'(req_cnt), 64'd0);
    check("rst_rsp_cnt", 64'(rsp_cnt), 64'd0);
    axis_req.tvalid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Three request beats, one cycle latency each.
    req_in.ready = 1'b1;
    rsp_in.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_beat(1'b0, a_vec[i]);
      check("abc_req_valid", 64'(req_out.valid), 64'd1);
      check("abc_req_data", 64'(req_out.data), 64'(a_vec[i]));
      check("abc_rsp_valid", 64'(rsp_out.valid), 64'd0);
    end
    @(posedge clk); #1;
    check("abc_drained", 64'(req_out.valid), 64'd0);
    check("abc_req_cnt", 64'(req_cnt), 64'd3);
    check("abc_seen_n", 64'(req_seen.size()), 64'd3);
    for (int i = 0; i < 3 && i < req_seen.size(); i++) check("abc_order", 64'(req_seen[i]), 64'(a_vec[i]));

    // Interleaved headers split onto both channels.
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      send_beat(1'(i % 2), d_vec[i]);
      if (i % 2 == 0) check("ilv_req_data", 64'(req_out.data), 64'(d_vec[i]));
      else            check("ilv_rsp_data", 64'(rsp_out.data), 64'(d_vec[i]));
    end
    @(posedge clk); #1;
    check("ilv_req_cnt", 64'(req_cnt), 64'd2);
    check("ilv_rsp_cnt", 64'(rsp_cnt), 64'd2);
    check("ilv_req_seen1", 64'(req_seen.size() > 1 ? req_seen[1] : 32'h0), 64'(d_vec[2]));
    check("ilv_rsp_seen1", 64'(rsp_seen.size() > 1 ? rsp_seen[1] : 32'h0), 64'(d_vec[3]));

    // Fill the response FIFO, stall a fifth beat, then show requests still pass.
    apply_reset();
    rsp_in.ready = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(1'b1, r_vec[i]);
    check("hol_rsp_cnt4", 64'(rsp_cnt), 64'd4);
    check("hol_rsp_head", 64'(rsp_out.data), 64'(r_vec[0]));
    axis_req.tvalid = 1'b1;
    axis_req.t.data = {1'b1, r_vec[4]};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hol_stall_tready", 64'(axis_rsp.tready), 64'd0);
    end
    @(posedge clk); #1;
    axis_req.tvalid = 1'b0;
    @(posedge clk); #1;
    check("hol_rsp_cnt_held", 64'(rsp_cnt), 64'd4);
    send_beat(1'b0, 32'h0000_0E0E);
    check("hol_req_valid", 64'(req_out.valid), 64'd1);
    check("hol_req_data", 64'(req_out.data), 64'h0E0E);
    check("hol_req_cnt", 64'(req_cnt), 64'd1);
    check("hol_rsp_head_kept", 64'(rsp_out.data), 64'(r_vec[0]));

    // Pop and new beat in the same cycle: full FIFO still refuses it.
    @(posedge clk); #1;
    axis_req.tvalid = 1'b1;
    axis_req.t.data = {1'b1, r_vec[4]};
    rsp_in.ready = 1'b1;
    @(negedge clk);
    check("full_pop_tready", 64'(axis_rsp.tready), 64'd0);
    @(posedge clk); #1;
    rsp_in.ready = 1'b0;
    @(negedge clk);
    check("retry_tready", 64'(axis_rsp.tready), 64'd1);
    check("retry_rsp_head", 64'(rsp_out.data), 64'(r_vec[1]));
    @(posedge clk); #1;
    axis_req.tvalid = 1'b0;
    check("retry_rsp_cnt", 64'(rsp_cnt), 64'd5);
    rsp_in.ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("order_rsp_n", 64'(rsp_seen.size()), 64'd5);
    for (int i = 0; i < 5 && i < rsp_seen.size(); i++) check("order_rsp", 64'(rsp_seen[i]), 64'(r_vec[i]));

    // Counter saturation on the 4-bit instance.
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      send_beat(1'b0, 32'(i));
      if (i == 13) check("sat_cnt14", 64'(req_cnt_sat), 64'd14);
      if (i == 14) check("sat_cnt15", 64'(req_cnt_sat), 64'd15);
    end
    check("sat_cnt_final", 64'(req_cnt_sat), 64'd15);
    check("wide_cnt_final", 64'(req_cnt), 64'd20);

    // Reset with flits buffered on both channels.
    apply_reset();
    req_in.ready = 1'b0;
    rsp_in.ready = 1'b0;
    send_beat(1'b0, 32'h1111_0000);
    send_beat(1'b0, 32'h1111_0001);
    send_beat(1'b1, 32'h2222_0000);
    send_beat(1'b1, 32'h2222_0001);
    check("pre_rst_req_cnt", 64'(req_cnt), 64'd2);
    check("pre_rst_rsp_cnt", 64'(rsp_cnt), 64'd2);
    rst_n = 1'b0;
    axis_req.tvalid = 1'b1;
    axis_req.t.data = {1'b0, 32'h3333_0000};
    @(negedge clk);
    check("mid_rst_tready", 64'(axis_rsp.tready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_req_valid", 64'(req_out.valid), 64'd0);
    check("mid_rst_rsp_valid", 64'(rsp_out.valid), 64'd0);
    check("mid_rst_req_cnt", 64'(req_cnt), 64'd0);
    check("mid_rst_rsp_cnt", 64'(rsp_cnt), 64'd0);
    check("mid_rst_tready2", 64'(axis_rsp.tready), 64'd0);
    @(posedge clk); #1;
    axis_req.tvalid = 1'b0;
    rst_n = 1'b1;
    req_in.ready = 1'b1;
    rsp_in.ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_req_valid", 64'(req_out.valid), 64'd0);
    check("post_rst_rsp_valid", 64'(rsp_out.valid), 64'd0);
    check("post_rst_seen", 64'(req_seen.size() + rsp_seen.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
